// File: rtl/eth_rx_frame_parser.sv
`timescale 1ns/1ps
// eth_rx_frame_parser
// GMII receive parser. It strips the preamble and SFD, then tags each frame byte
// with its field and delays it through a 4-deep pipe so that the FCS bytes can be
// retagged once RX_DV falls. It also produces a per-frame CRC, length and rx_er
// verdict.
//
// state    | meaning
// IDLE     | waiting for RX_DV to rise
// PREAMBLE | receiving 0x55 bytes (1..7) until the SFD
// DA       | post-SFD bytes 1-6
// SA       | post-SFD bytes 7-12
// LEN_TYPE | post-SFD bytes 13-14
// PAYLOAD  | post-SFD bytes 15 onward (FCS is only known when RX_DV falls)
// ERROR    | bad preamble or RX_DV already high out of reset; drop until RX_DV low
module eth_rx_frame_parser #(
  parameter int pDATA_WIDTH        = 8,
  parameter int pMIN_PACKET_LENGHT = 64,
  parameter int pMAX_PACKET_LENGHT = 1536
) (
  input  logic                   iclk,
  input  logic                   i_rst,
  input  logic                   irx_dv,
  input  logic [pDATA_WIDTH-1:0] irx_d,
  input  logic                   irx_er,
  output logic                   o_rx_dv,
  output logic [pDATA_WIDTH-1:0] o_rx_d,
  output logic                   o_rx_er,
  output logic [2:0]             o_fsm_state,
  output logic [10:0]            o_byte_cnt,
  output logic                   o_frame_done,
  output logic                   o_frame_good,
  output logic                   o_crc_err,
  output logic                   o_len_err
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_LEN     = 11'(pMIN_PACKET_LENGHT);
  localparam logic [10:0] MAX_LEN     = 11'(pMAX_PACKET_LENGHT);
  localparam logic [10:0] CNT_SAT     = 11'h7FF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_PRE = 3'd1, ST_DA = 3'd2, ST_SA = 3'd3,
    ST_LT   = 3'd4, ST_PL  = 3'd5, ST_FCS = 3'd6, ST_ERR = 3'd7
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             pre_left_q, pre_left_d;
  logic                   dv_prev_q;
  logic [10:0]            cnt_q;
  logic [31:0]            crc_q;
  logic                   er_q;
  logic                   pv_q [4];
  logic [pDATA_WIDTH-1:0] pd_q [4];
  logic                   pe_q [4];
  logic [2:0]             pt_q [4];
  logic [10:0]            pend_cnt_q;
  logic                   pend_crc_err_q, pend_er_q;
  logic [1:0]             drain_q;
  logic                   done_q, good_q, crc_err_q, len_err_q;
  logic [10:0]            byte_cnt_q;
  logic                   in_frame, fwd, eof, sfd, pend_len_err;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [pDATA_WIDTH-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < pDATA_WIDTH; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  // State register; dv_prev resets high so RX_DV already asserted at release is not a rise
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      pre_left_q <= 3'd0;
      dv_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      pre_left_q <= pre_left_d;
      dv_prev_q  <= irx_dv;
    end
  end

  // Next-state logic; pre_left counts down the 0x55 bytes still allowed
  always_comb begin
    state_d    = state_q;
    pre_left_d = pre_left_q;
    case (state_q)
      ST_IDLE: if (irx_dv) begin
        if (!dv_prev_q && irx_d == 8'h55) begin
          state_d    = ST_PRE;
          pre_left_d = 3'd6;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_PRE: begin
        if (!irx_dv)                                 state_d = ST_IDLE;
        else if (irx_d == 8'hD5)                     state_d = ST_DA;
        else if (irx_d == 8'h55 && pre_left_q != 0)  pre_left_d = pre_left_q - 3'd1;
        else                                         state_d = ST_ERR;
      end
      ST_DA:   if (!irx_dv) state_d = ST_IDLE; else if (cnt_q == 11'd5)  state_d = ST_SA;
      ST_SA:   if (!irx_dv) state_d = ST_IDLE; else if (cnt_q == 11'd11) state_d = ST_LT;
      ST_LT:   if (!irx_dv) state_d = ST_IDLE; else if (cnt_q == 11'd13) state_d = ST_PL;
      ST_PL:   if (!irx_dv) state_d = ST_IDLE;
      ST_ERR:  if (!irx_dv) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM-derived strobes and the visible field tag (FCS overrides the head entry on RX_DV fall)
  always_comb begin
    in_frame = (state_q == ST_DA) || (state_q == ST_SA) || (state_q == ST_LT) || (state_q == ST_PL);
    fwd      = in_frame && irx_dv;
    eof      = in_frame && !irx_dv;
    sfd      = (state_q == ST_PRE) && irx_dv && (irx_d == 8'hD5);
    if (pv_q[3]) o_fsm_state = eof ? ST_FCS : pt_q[3];
    else         o_fsm_state = state_q;
  end

  // Four-stage delay pipe; the entries still inside are retagged FCS when the frame ends
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 4; i++) begin
        pv_q[i] <= 1'b0;
        pd_q[i] <= '0;
        pe_q[i] <= 1'b0;
        pt_q[i] <= ST_IDLE;
      end
    end else begin
      pv_q[0] <= fwd;
      pd_q[0] <= fwd ? irx_d : '0;
      pe_q[0] <= fwd & irx_er;
      pt_q[0] <= fwd ? state_q : ST_IDLE;
      for (int i = 1; i < 4; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pt_q[i] <= (eof && pv_q[i-1]) ? ST_FCS : pt_q[i-1];
      end
    end
  end

  // Per-frame byte count, CRC and sticky rx_er, restarted at every SFD
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= 11'd0;
      crc_q <= 32'hFFFFFFFF;
      er_q  <= 1'b0;
    end else if (sfd) begin
      cnt_q <= 11'd0;
      crc_q <= 32'hFFFFFFFF;
      er_q  <= 1'b0;
    end else if (fwd) begin
      if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 11'd1;
      crc_q <= crc_upd(crc_q, irx_d);
      er_q  <= er_q | irx_er;
    end
  end

  assign pend_len_err = (pend_cnt_q < MIN_LEN) || (pend_cnt_q > MAX_LEN);

  // Verdict: snapshot at RX_DV fall, publish once the pipe has drained, so a following frame can start
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      pend_cnt_q     <= 11'd0;
      pend_crc_err_q <= 1'b0;
      pend_er_q      <= 1'b0;
      drain_q        <= 2'd0;
      done_q         <= 1'b0;
      good_q         <= 1'b0;
      crc_err_q      <= 1'b0;
      len_err_q      <= 1'b0;
      byte_cnt_q     <= 11'd0;
    end else begin
      done_q <= 1'b0;
      if (eof) begin
        pend_cnt_q     <= cnt_q;
        pend_crc_err_q <= (crc_q != CRC_RESIDUE);
        pend_er_q      <= er_q;
        drain_q        <= 2'd3;
      end else if (drain_q != 2'd0) begin
        drain_q <= drain_q - 2'd1;
        if (drain_q == 2'd1) begin
          done_q     <= 1'b1;
          byte_cnt_q <= pend_cnt_q;
          crc_err_q  <= pend_crc_err_q;
          len_err_q  <= pend_len_err;
          good_q     <= !pend_crc_err_q && !pend_len_err && !pend_er_q;
        end
      end
    end
  end

  assign o_rx_dv      = pv_q[3];
  assign o_rx_d       = pd_q[3];
  assign o_rx_er      = pe_q[3];
  assign o_byte_cnt   = byte_cnt_q;
  assign o_frame_done = done_q;
  assign o_frame_good = good_q;
  assign o_crc_err    = crc_err_q;
  assign o_len_err    = len_err_q;

endmodule
